// File: rtl/pe_array_sched.sv
// pe_array_sched: job sequencer for a num1 x num2 PE array.
// Preloads num1 weight rows, streams k_num activation vectors through
// per-lane skew lines, tracks column result validity and drains the
// array before reporting completion.
module pe_array_sched #(
  parameter int num1   = 4,
  parameter int num2   = 4,
  parameter int PE_LAT = 4
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 start,
  input  logic [15:0]          k_num,
  output logic                 busy,
  output logic                 done,
  input  logic                 w_valid,
  output logic                 w_ready,
  input  logic [num2*32-1:0]   w_data,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [num1*32-1:0]   a_data,
  output logic                 EN,
  output logic                 SELECTOR,
  output logic                 OPSEL,
  output logic                 W_EN,
  output logic [num2*32-1:0]   in_weight_above,
  output logic [num1*32-1:0]   active_left,
  output logic [num2-1:0]      col_valid
);

  // Weight row counter only needs to reach num1-1; the last fire leaves LOAD_W.
  localparam int WCW = (num1 > 1) ? $clog2(num1) : 1;
  localparam logic [WCW-1:0] W_LAST = WCW'(num1 - 1);
  // Valid pipeline: bit k carries a fire from k+1 cycles ago.
  localparam int VLEN = PE_LAT + num2 - 1;
  // Pipeline holding only the last column's pulse means the last vector is leaving.
  localparam logic [VLEN-1:0] V_LAST_ONLY = VLEN'(1) << (VLEN - 1);

  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;

  state_t               state_q, state_d;
  logic [15:0]          k_q, k_d;
  logic [WCW-1:0]       w_cnt_q, w_cnt_d;
  logic [15:0]          a_cnt_q, a_cnt_d;
  logic                 w_en_q, w_en_d;
  logic [num2*32-1:0]   wgt_q, wgt_d;
  logic                 sel_q, sel_d;
  logic [VLEN-1:0]      v_q, v_d;
  logic                 w_fire;
  logic                 a_fire;

  assign w_fire = w_valid & w_ready;
  assign a_fire = a_valid & a_ready;

  // State register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD_W;
      LOAD_W:  if (w_fire && (w_cnt_q == W_LAST)) state_d = (k_q != 16'd0) ? STREAM : DONE;
      STREAM:  if (a_fire && ((a_cnt_q + 16'd1) == k_q)) state_d = DRAIN;
      DRAIN:   if (v_q == V_LAST_ONLY) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    busy    = (state_q != IDLE);
    EN      = (state_q != IDLE);
    done    = (state_q == DONE);
    w_ready = (state_q == LOAD_W);
    a_ready = (state_q == STREAM);
    OPSEL   = 1'b1;
  end

  // Job length latch and the weight/activation fire counters
  always_comb begin
    k_d     = k_q;
    w_cnt_d = w_cnt_q;
    a_cnt_d = a_cnt_q;
    if ((state_q == IDLE) && start) begin
      k_d     = k_num;
      w_cnt_d = '0;
      a_cnt_d = '0;
    end else begin
      if (w_fire) w_cnt_d = w_cnt_q + WCW'(1);
      if (a_fire) a_cnt_d = a_cnt_q + 16'd1;
    end
  end

  // Weight shift is one cycle behind the fire; idle cycles drive zero and pause the shift
  always_comb begin
    w_en_d = w_fire;
    wgt_d  = w_fire ? w_data : '0;
    sel_d  = !((state_q == STREAM) || (state_q == DRAIN));
  end

  // Column valid pipeline fed by activation fires
  always_comb begin
    v_d    = '0;
    v_d[0] = a_fire;
    for (int k = 1; k < VLEN; k++) v_d[k] = v_q[k-1];
  end

  // Control and pipeline registers
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      k_q     <= '0;
      w_cnt_q <= '0;
      a_cnt_q <= '0;
      w_en_q  <= 1'b0;
      wgt_q   <= '0;
      sel_q   <= 1'b1;
      v_q     <= '0;
    end else begin
      k_q     <= k_d;
      w_cnt_q <= w_cnt_d;
      a_cnt_q <= a_cnt_d;
      w_en_q  <= w_en_d;
      wgt_q   <= wgt_d;
      sel_q   <= sel_d;
      v_q     <= v_d;
    end
  end

  assign W_EN            = w_en_q;
  assign in_weight_above = wgt_q;
  assign SELECTOR        = sel_q;

  // Column j result is valid PE_LAT-1+j stages down the valid pipeline
  for (genvar gj = 0; gj < num2; gj++) begin : g_col
    assign col_valid[gj] = v_q[PE_LAT - 1 + gj];
  end

  // Skew line per activation lane: lane i is i+1 registers deep, zeros fill idle cycles
  for (genvar gi = 0; gi < num1; gi++) begin : g_lane
    logic [31:0] sk_q [0:gi];
    logic [31:0] sk_d [0:gi];

    // Shift stage: new sample enters at stage 0
    always_comb begin
      for (int s = 0; s <= gi; s++) sk_d[s] = '0;
      sk_d[0] = a_fire ? a_data[32*gi +: 32] : 32'd0;
      for (int s = 1; s <= gi; s++) sk_d[s] = sk_q[s-1];
    end

    // Skew registers
    always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
        for (int s = 0; s <= gi; s++) sk_q[s] <= '0;
      end else begin
        for (int s = 0; s <= gi; s++) sk_q[s] <= sk_d[s];
      end
    end

    assign active_left[32*gi +: 32] = sk_q[gi];
  end

endmodule

// File: tb/tb_pe_array_sched.sv
// tb_pe_array_sched: directed checks of the PE array job sequencer.
module tb_pe_array_sched;

  localparam int N1  = 4;
  localparam int N2  = 4;
  localparam int LAT = 4;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [15:0]       k_num;
  logic              busy, done;
  logic              w_valid, w_ready;
  logic [N2*32-1:0]  w_data;
  logic              a_valid, a_ready;
  logic [N1*32-1:0]  a_data;
  logic              EN, SELECTOR, OPSEL, W_EN;
  logic [N2*32-1:0]  in_weight_above;
  logic [N1*32-1:0]  active_left;
  logic [N2-1:0]     col_valid;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;

  pe_array_sched #(.num1(N1), .num2(N2), .PE_LAT(LAT)) dut (
    .CLK             (clk),
    .RESET           (rst_n),
    .start           (start),
    .k_num           (k_num),
    .busy            (busy),
    .done            (done),
    .w_valid         (w_valid),
    .w_ready         (w_ready),
    .w_data          (w_data),
    .a_valid         (a_valid),
    .a_ready         (a_ready),
    .a_data          (a_data),
    .EN              (EN),
    .SELECTOR        (SELECTOR),
    .OPSEL           (OPSEL),
    .W_EN            (W_EN),
    .in_weight_above (in_weight_above),
    .active_left     (active_left),
    .col_valid       (col_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, failed);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [31:0] act_lane(input int n, input int i);
    if (n == 0) return 32'h3F80_0000;
    return 32'h4000_0000 | 32'(n << 8) | 32'(i);
  endfunction

  function automatic logic [N1*32-1:0] act_vec(input int n);
    logic [N1*32-1:0] v;
    for (int i = 0; i < N1; i++) v[32*i +: 32] = act_lane(n, i);
    return v;
  endfunction

  function automatic logic [N2*32-1:0] wgt_vec(input int r);
    logic [N2*32-1:0] v;
    for (int j = 0; j < N2; j++) v[32*j +: 32] = 32'h5A00_0000 | 32'(r << 8) | 32'(j);
    return v;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ":busy"}, busy, 0);
    chk({tag, ":done"}, done, 0);
    chk({tag, ":w_ready"}, w_ready, 0);
    chk({tag, ":a_ready"}, a_ready, 0);
    chk({tag, ":EN"}, EN, 0);
    chk({tag, ":W_EN"}, W_EN, 0);
    chk({tag, ":SELECTOR"}, SELECTOR, 1);
    chk({tag, ":OPSEL"}, OPSEL, 1);
    chk({tag, ":in_weight_above"}, in_weight_above, 0);
    chk({tag, ":active_left"}, active_left, 0);
    chk({tag, ":col_valid"}, col_valid, 0);
  endtask

  // Pulse start in IDLE, then scramble k_num so only the latched value can matter
  task automatic begin_job(input logic [15:0] k);
    start = 1'b1;
    k_num = k;
    step();
    start = 1'b0;
    k_num = 16'hBEEF;
    chk("job_busy", busy, 1);
    chk("job_EN", EN, 1);
    chk("job_w_ready", w_ready, 1);
    chk("job_done", done, 0);
    chk("job_SELECTOR", SELECTOR, 1);
  endtask

  // Offer num1 weight rows, optionally with a gap before the last row
  task automatic load_weights(input int gap_len, input bit poke);
    int r, g, pulses;
    bit v;
    r = 0; g = 0; pulses = 0;
    for (int c = 0; c < N1 + gap_len; c++) begin
      chk("lw_w_ready", w_ready, 1);
      chk("lw_a_ready", a_ready, 0);
      v = !((r == N1 - 1) && (g < gap_len));
      if (!v) g++;
      w_valid = v;
      w_data  = v ? wgt_vec(r) : {N2{32'hDEAD_BEEF}};
      if (poke && c == 1) begin
        start = 1'b1;
        k_num = 16'd9;
      end
      step();
      w_valid = 1'b0;
      start   = 1'b0;
      chk("W_EN", W_EN, v);
      chk("in_weight_above", in_weight_above, v ? wgt_vec(r) : '0);
      chk("lw_col_valid", col_valid, 0);
      if (W_EN) pulses++;
      if (v) r++;
    end
    chk("w_en_pulses", pulses, N1);
    chk("lw_w_ready_after", w_ready, 0);
  endtask

  // Stream activations following pat (bit c = a_valid in stream cycle c) through DONE
  task automatic run_stream(input int k, input logic [15:0] pat, input int plen, input bit poke);
    int fc[$];
    int fn[$];
    int nf, last;
    bit v, fin;
    logic [N1*32-1:0] exp_al;
    logic [N2-1:0]    exp_cv;
    nf = 0; last = 0; fin = 0;
    for (int c = 0; (c < plen + LAT + N2 + 2) && !fin; c++) begin
      chk("a_ready", a_ready, (nf < k));
      v = (c < plen) && pat[c];
      a_valid = v;
      a_data  = v ? act_vec(nf) : {N1{32'hBAD0_0BAD}};
      if (v) begin
        fc.push_back(cyc);
        fn.push_back(nf);
        nf++;
        last = cyc;
      end
      if (poke && c == 1) begin
        start = 1'b1;
        k_num = 16'd1;
      end
      step();
      a_valid = 1'b0;
      start   = 1'b0;
      exp_al = '0;
      exp_cv = '0;
      foreach (fc[q]) begin
        for (int i = 0; i < N1; i++)
          if (cyc == fc[q] + 1 + i) exp_al[32*i +: 32] = act_lane(fn[q], i);
        for (int j = 0; j < N2; j++)
          if (cyc == fc[q] + LAT + j) exp_cv[j] = 1'b1;
      end
      chk("active_left", active_left, exp_al);
      chk("col_valid", col_valid, exp_cv);
      fin = (nf == k) && (cyc == last + LAT + N2);
      chk("done", done, fin);
      chk("st_busy", busy, 1);
      chk("st_EN", EN, 1);
      chk("st_SELECTOR", SELECTOR, 0);
      chk("st_W_EN", W_EN, 0);
    end
    // Now in the DONE cycle
    if (poke) begin
      start = 1'b1;
      k_num = 16'd2;
    end
    step();
    start = 1'b0;
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_EN", EN, 0);
    chk("idle_SELECTOR", SELECTOR, 1);
    chk("idle_w_ready", w_ready, 0);
    step();
    chk("idle_hold_busy", busy, 0);
    chk("idle_hold_w_ready", w_ready, 0);
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    k_num   = '0;
    w_valid = 1'b0;
    w_data  = '0;
    a_valid = 1'b0;
    a_data  = '0;

    // Reset state
    #12;
    chk_reset_outputs("rst_init");
    step();
    step();
    #4 rst_n = 1'b1;
    step();
    chk_reset_outputs("post_rst");

    // k=2, back-to-back weights, two back-to-back vectors (first is 0x3F800000 in every lane)
    begin_job(16'd2);
    load_weights(0, 0);
    run_stream(2, 16'b0000_0000_0000_0011, 2, 0);

    // k=1 with a 3-cycle weight gap before the last row
    begin_job(16'd1);
    load_weights(3, 0);
    run_stream(1, 16'b0000_0000_0000_0001, 1, 0);

    // k=3 gapped activations; start pulses in LOAD_W, STREAM and DONE are ignored
    begin_job(16'd3);
    load_weights(0, 1);
    run_stream(3, 16'b0000_0000_0000_1101, 4, 1);

    // k=0: straight from LOAD_W to DONE
    begin_job(16'd0);
    load_weights(0, 0);
    chk("k0_done", done, 1);
    chk("k0_busy", busy, 1);
    chk("k0_a_ready", a_ready, 0);
    chk("k0_col_valid", col_valid, 0);
    chk("k0_SELECTOR", SELECTOR, 1);
    step();
    chk("k0_idle_done", done, 0);
    chk("k0_idle_busy", busy, 0);
    chk("k0_idle_a_ready", a_ready, 0);
    chk("k0_idle_col_valid", col_valid, 0);

    // Asynchronous reset mid-STREAM, then a fresh job
    begin_job(16'd3);
    load_weights(0, 0);
    a_valid = 1'b1;
    a_data  = act_vec(0);
    step();
    a_valid = 1'b0;
    chk("pre_rst_lane0", active_left[31:0], 32'h3F80_0000);
    chk("pre_rst_a_ready", a_ready, 1);
    #3 rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    step();
    step();
    chk_reset_outputs("rst_hold");
    #4 rst_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      step();
      chk_reset_outputs("rst_after");
    end
    begin_job(16'd2);
    load_weights(0, 0);
    run_stream(2, 16'b0000_0000_0000_0101, 3, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/pe_array_sched.md
PE_ARRAY_SCHED -- requirements
Module: pe_array_sched

Interface
REQ-001 SHALL have parameter num1, default 4: PE array rows (activation lanes).
REQ-002 SHALL have parameter num2, default 4: PE array columns (weight and sum lanes).
REQ-003 SHALL have parameter PE_LAT, default 4 (legal range >= 1): cycles from an activation accept to column-0 result valid.
REQ-004 SHALL have port CLK  in  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port RESET  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  in  1  pulse that begins a job; sampled only in IDLE.
REQ-007 SHALL have port k_num  in  16  number of activation vectors in the job; latched on start.
REQ-008 SHALL have port busy  out  1  high from the cycle after start is accepted through DONE.
REQ-009 SHALL have port done  out  1  one-cycle completion pulse.
REQ-010 SHALL have ports w_valid in 1, w_ready out 1, w_data in num2*32: weight-row handshake.
REQ-011 SHALL have ports a_valid in 1, a_ready out 1, a_data in num1*32: activation-vector handshake.
REQ-012 SHALL have ports EN, SELECTOR, OPSEL and W_EN, each out 1: PE array controls.
REQ-013 SHALL have port in_weight_above  out  num2*32  weight row to the array.
REQ-014 SHALL have port active_left  out  num1*32  skewed activations to the array.
REQ-015 SHALL have port col_valid  out  num2  out_sum_final lane j valid when bit j is high.

Function
REQ-016 SHALL implement the states IDLE, LOAD_W, STREAM, DRAIN and DONE.
REQ-017 SHALL move IDLE->LOAD_W on start=1 and latch k_num; start in any other state SHALL be ignored.
REQ-018 SHALL drive w_ready=1 only in LOAD_W; a weight fire is w_valid&w_ready.
REQ-019 SHALL, on a weight fire in cycle t, drive W_EN=1 and in_weight_above=w_data in cycle t+1; otherwise W_EN=0 and in_weight_above=0, so the weight shift pauses while w_valid is low.
REQ-020 SHALL leave LOAD_W after the num1-th weight fire: to STREAM if k_num!=0, to DONE if k_num=0.
REQ-021 SHALL drive a_ready=1 only in STREAM; an activation fire is a_valid&a_ready.
REQ-022 SHALL present lane i (bits 32i+31:32i) of a vector fired in cycle t on active_left lane i in cycle t+1+i.
REQ-023 SHALL shift zeros into the skew lines on non-fire cycles in STREAM and DRAIN, with no bubble collapse.
REQ-024 SHALL assert col_valid[j] in cycle t+PE_LAT+j for a vector fired in cycle t; col_valid SHALL be 0 at all other times.
REQ-025 SHALL count activation fires with a 16-bit counter and move STREAM->DRAIN on the k_num-th fire.
REQ-026 SHALL stay in DRAIN until the cycle in which col_valid[num2-1] for the last vector asserts, then enter DONE.
REQ-027 SHALL assert done=1 for exactly the one DONE cycle, then return to IDLE; a start arriving in that DONE cycle SHALL be ignored.
REQ-028 SHALL drive SELECTOR in cycle t+1 to 0 if the state in cycle t was STREAM or DRAIN, else 1.
REQ-029 SHALL drive EN=1 whenever state is not IDLE, and OPSEL=1 constantly.

Reset
REQ-030 SHALL, on RESET=0 and independent of CLK, force state IDLE and clear both counters and all skew and valid pipelines.
REQ-031 SHALL hold these output values during and after reset: busy=0, done=0, w_ready=0, a_ready=0, EN=0, W_EN=0, SELECTOR=1, OPSEL=1, in_weight_above=0, active_left=0, col_valid=0.
REQ-032 SHALL, if reset is asserted mid-job, discard the job, and SHALL begin no job until a new start arrives in IDLE.

Verification
REQ-033 SHALL be verified with defaults and k_num=2: 4 weight rows offered back-to-back must give W_EN high for 4 consecutive cycles with matching in_weight_above; then A=0x3F800000 in every lane, fired at t0, must appear on active_left lane i at t0+1+i.
REQ-034 SHALL be verified with w_valid low for 3 cycles between row 2 and row 3: W_EN must be 0 and in_weight_above must be 0 for those 3 cycles, and exactly 4 W_EN pulses must occur.
REQ-035 SHALL be verified with k_num=3 and a_valid gapped (fire, idle, fire, fire): the skew lanes must show a zero bubble, col_valid[j] must pulse exactly 3 times per lane at fire+4+j, and done must assert at the last fire+4+3+1.
REQ-036 SHALL be verified with k_num=0: after 4 weight fires, done must assert in the next cycle, a_ready must never be 1, and col_valid must stay 0.
REQ-037 SHALL be verified by asserting RESET=0 mid-STREAM, between clock edges: all outputs must immediately take their REQ-031 values, and after release a fresh start must run a full job correctly.
REQ-038 SHALL be verified by pulsing start during LOAD_W, STREAM and DONE: the pulses must have no effect and k_num must not be re-latched.
